// File: rtl/muldiv_unit.sv
// Iterative RISC-V M-extension multiply/divide: shift-add multiply, restoring divide, one bit per cycle.
// Optional build macro MULDIV_FAST_PATH_EN: trivial cases (div by zero, signed overflow, multiply by zero) finish on the start edge.
module muldiv_unit #(
   parameter int XLEN  = 32,
   parameter int CNT_W = $clog2(XLEN + 1)
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            start,
   input  logic [2:0]      funct3,
   input  logic [XLEN-1:0] op_a,
   input  logic [XLEN-1:0] op_b,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] result
);

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_FIN = 2'd2} state_t;

   localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

   state_t            r_state, w_next;
   logic [2:0]        r_op;
   logic [XLEN-1:0]   r_a, r_m, r_hi, r_lo, r_result;
   logic              r_sa, r_sb, r_div0, r_done;
   logic [CNT_W-1:0]  r_cnt;

   logic              w_sa, w_sb, w_fast;
   logic [XLEN-1:0]   w_mag_a, w_mag_b, w_fin_res;
   logic [XLEN:0]     w_add, w_trial, w_diff;
   logic [2*XLEN-1:0] w_prod, w_prod_c;
   logic [XLEN-1:0]   w_quo_c, w_rem_c;

   // Only MULH/MULHSU/DIV/REM treat op_a as signed; MULHSU leaves op_b unsigned.
   assign w_sa    = op_a[XLEN-1] & (funct3 == 3'b001 || funct3 == 3'b010 ||
                                    funct3 == 3'b100 || funct3 == 3'b110);
   assign w_sb    = op_b[XLEN-1] & (funct3 == 3'b001 || funct3 == 3'b100 || funct3 == 3'b110);
   assign w_mag_a = w_sa ? -op_a : op_a;
   assign w_mag_b = w_sb ? -op_b : op_b;

`ifdef MULDIV_FAST_PATH_EN
   logic            w_div_zero_in, w_ovf_in, w_mul_zero_in;
   logic [XLEN-1:0] w_fast_res;
   assign w_div_zero_in = funct3[2] && (op_b == '0);
   assign w_ovf_in      = (funct3 == 3'b100 || funct3 == 3'b110) && (op_a == MIN_NEG) && (op_b == '1);
   assign w_mul_zero_in = !funct3[2] && (op_a == '0 || op_b == '0);
   assign w_fast        = w_div_zero_in | w_ovf_in | w_mul_zero_in;
   always_comb begin
      w_fast_res = '0;
      if (w_div_zero_in)  w_fast_res = funct3[1] ? op_a : '1;
      else if (w_ovf_in)  w_fast_res = funct3[1] ? '0 : op_a;
   end
`else
   assign w_fast = 1'b0;
`endif

   // Working pair {r_hi, r_lo}: product during multiply, {remainder, quotient} during divide.
   assign w_add    = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_m} : '0);
   assign w_trial  = {r_hi, r_lo[XLEN-1]};
   assign w_diff   = w_trial - {1'b0, r_m};
   assign w_prod   = {r_hi, r_lo};
   assign w_prod_c = (r_sa ^ r_sb) ? -w_prod : w_prod;
   assign w_quo_c  = (r_sa ^ r_sb) ? -r_lo : r_lo;
   assign w_rem_c  = r_sa ? -r_hi : r_hi;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (start && !w_fast) w_next = S_RUN;
         S_RUN:   if (r_cnt == CNT_W'(XLEN - 1)) w_next = S_FIN;
         S_FIN:   w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_comb begin
      busy      = (r_state != S_IDLE);
      w_fin_res = '0;
      case (r_op)
         3'b000:                 w_fin_res = w_prod_c[XLEN-1:0];
         3'b001, 3'b010, 3'b011: w_fin_res = w_prod_c[2*XLEN-1:XLEN];
         3'b100, 3'b101:         w_fin_res = r_div0 ? '1 : w_quo_c;
         default:                w_fin_res = r_div0 ? r_a : w_rem_c;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_op     <= '0;
         r_a      <= '0;
         r_m      <= '0;
         r_hi     <= '0;
         r_lo     <= '0;
         r_sa     <= 1'b0;
         r_sb     <= 1'b0;
         r_div0   <= 1'b0;
         r_cnt    <= '0;
         r_result <= '0;
         r_done   <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: if (start) begin
`ifdef MULDIV_FAST_PATH_EN
               if (w_fast) begin
                  r_result <= w_fast_res;
                  r_done   <= 1'b1;
               end else
`endif
               begin
                  r_op   <= funct3;
                  r_a    <= op_a;
                  r_sa   <= w_sa;
                  r_sb   <= w_sb;
                  r_div0 <= (op_b == '0);
                  r_cnt  <= '0;
                  r_hi   <= '0;
                  r_m    <= funct3[2] ? w_mag_b : w_mag_a;
                  r_lo   <= funct3[2] ? w_mag_a : w_mag_b;
               end
            end
            S_RUN: begin
               r_cnt <= r_cnt + CNT_W'(1);
               if (r_op[2]) begin
                  r_hi <= w_diff[XLEN] ? w_trial[XLEN-1:0] : w_diff[XLEN-1:0];
                  r_lo <= {r_lo[XLEN-2:0], ~w_diff[XLEN]};
               end else begin
                  r_hi <= w_add[XLEN:1];
                  r_lo <= {w_add[0], r_lo[XLEN-1:1]};
               end
            end
            S_FIN: begin
               r_result <= w_fin_res;
               r_done   <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign done   = r_done;
   assign result = r_result;

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: directed vector table, corner-case sequences, and random ops against an arithmetic reference model.
module tb_muldiv_unit;
  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            reset, start;
  logic [2:0]      funct3;
  logic [XLEN-1:0] op_a, op_b, result;
  logic            busy, done;

  int checks = 0;
  int errors = 0;
  logic [XLEN-1:0] exp_q[$];

  typedef struct {
    logic [2:0]      f;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [XLEN-1:0] expv;
  } vec_t;
  vec_t vecs[16];

  muldiv_unit #(.XLEN(XLEN)) dut (
    .clk(clk), .reset(reset), .start(start), .funct3(funct3),
    .op_a(op_a), .op_b(op_b), .busy(busy), .done(done), .result(result)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic [XLEN-1:0] ref_model(input logic [2:0] f, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
    logic signed [2*XLEN-1:0] sa, sb;
    logic [2*XLEN-1:0] ua, ub, p;
    logic signed [XLEN-1:0] q;
    sa = {{XLEN{a[XLEN-1]}}, a};
    sb = {{XLEN{b[XLEN-1]}}, b};
    ua = {{XLEN{1'b0}}, a};
    ub = {{XLEN{1'b0}}, b};
    case (f)
      3'd0: begin p = ua * ub; return p[XLEN-1:0]; end
      3'd1: begin p = sa * sb; return p[2*XLEN-1:XLEN]; end
      3'd2: begin p = sa * ub; return p[2*XLEN-1:XLEN]; end
      3'd3: begin p = ua * ub; return p[2*XLEN-1:XLEN]; end
      3'd4: begin
        if (b == 0) return '1;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        q = $signed(a) / $signed(b);
        return q;
      end
      3'd5: return (b == 0) ? '1 : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return '0;
        q = $signed(a) % $signed(b);
        return q;
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  // Edge index (counting E0 as 0) after which done is expected high.
  function automatic int exp_lat(input logic [2:0] f, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
`ifdef MULDIV_FAST_PATH_EN
    if (f[2] && b == 0) return 0;
    if ((f == 3'd4 || f == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 0;
    if (!f[2] && (a == 0 || b == 0)) return 0;
`endif
    return XLEN + 1;
  endfunction

  function automatic logic [XLEN-1:0] pick_operand();
    case ($urandom_range(0, 5))
      0: return '0;
      1: return 32'd1;
      2: return '1;
      3: return 32'h8000_0000;
      4: return $urandom_range(0, 15);
      default: return $urandom;
    endcase
  endfunction

  // ---------------- driver / checker tasks ----------------
  task automatic chk(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, expv);
    end
  endtask

  // Called away from the clock edge; returns 1 time unit after the start edge E0.
  task automatic issue(input logic [2:0] f, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
    funct3 = f;
    op_a   = a;
    op_b   = b;
    start  = 1'b1;
    @(posedge clk);
    #1;
    start  = 1'b0;
    funct3 = 3'($urandom_range(0, 7));
    op_a   = $urandom;
    op_b   = $urandom;
  endtask

  task automatic wait_done(output logic [XLEN-1:0] res, output int lat, output int bcnt);
    lat  = 0;
    bcnt = 0;
    while (!done && lat < 200) begin
      if (busy) bcnt++;
      @(posedge clk);
      #1;
      lat++;
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL done_timeout actual=no_done expected=done_within_200_cycles");
    end
    res = result;
  endtask

  task automatic run_op(input string name, input logic [2:0] f, input logic [XLEN-1:0] a,
                        input logic [XLEN-1:0] b, input logic [XLEN-1:0] expv);
    logic [XLEN-1:0] res, got;
    int lat, bcnt;
    exp_q.push_back(expv);
    issue(f, a, b);
    wait_done(res, lat, bcnt);
    got = exp_q.pop_front();
    chk({name, "_result"}, res, got);
    chk({name, "_latency"}, 32'(lat), 32'(exp_lat(f, a, b)));
    chk({name, "_busy_cycles"}, 32'(bcnt), 32'(exp_lat(f, a, b)));
    chk({name, "_busy_at_done"}, {31'b0, busy}, 32'd0);
  endtask

  // ---------------- test ----------------
  initial begin
    logic [XLEN-1:0] res, a, b;
    logic [2:0] f;
    int lat, bcnt;

    vecs[0]  = '{3'd0, 32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB};
    vecs[1]  = '{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
    vecs[2]  = '{3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000};
    vecs[3]  = '{3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    vecs[4]  = '{3'd4, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD};
    vecs[5]  = '{3'd6, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF};
    vecs[6]  = '{3'd5, 32'hFFFF_FFF9, 32'd2,         32'h7FFF_FFFC};
    vecs[7]  = '{3'd7, 32'hFFFF_FFF9, 32'd2,         32'h0000_0001};
    vecs[8]  = '{3'd5, 32'd5,         32'd0,         32'hFFFF_FFFF};
    vecs[9]  = '{3'd7, 32'd5,         32'd0,         32'h0000_0005};
    vecs[10] = '{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000};
    vecs[11] = '{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000};
    vecs[12] = '{3'd0, 32'd3,         32'd4,         32'd12};
    vecs[13] = '{3'd0, 32'd0,         32'h1234_5678, 32'd0};
    vecs[14] = '{3'd4, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFFF};
    vecs[15] = '{3'd6, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9};

    // reset block
    reset = 1'b1; start = 1'b0; funct3 = '0; op_a = '0; op_b = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_busy", {31'b0, busy}, 32'd0);
    chk("reset_done", {31'b0, done}, 32'd0);
    chk("reset_result", result, 32'd0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // directed vector table
    for (int i = 0; i < 16; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].f, vecs[i].a, vecs[i].b, vecs[i].expv);
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d_done_one_cycle", i), {31'b0, done}, 32'd0);
    end

    // back-to-back: second start issued in the done cycle of the first
    issue(3'd0, 32'd11, 32'd13);
    wait_done(res, lat, bcnt);
    chk("b2b_first", res, 32'd143);
    issue(3'd5, 32'd100, 32'd7);
    wait_done(res, lat, bcnt);
    chk("b2b_second", res, 32'd14);
    chk("b2b_second_latency", 32'(lat), 32'(XLEN + 1));

    // start during RUN is ignored
    issue(3'd0, 32'd100, 32'd200);
    repeat (5) @(posedge clk);
    #1;
    funct3 = 3'd5; op_a = 32'd999; op_b = 32'd3; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(res, lat, bcnt);
    chk("ignore_start_result", res, 32'd20000);
    chk("ignore_start_latency", 32'(lat), 32'(XLEN + 1 - 6));

    // reset at iteration 10 aborts the operation
    issue(3'd0, 32'h1234, 32'd5);
    repeat (10) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    chk("abort_busy", {31'b0, busy}, 32'd0);
    chk("abort_done", {31'b0, done}, 32'd0);
    chk("abort_result", result, 32'd0);
    @(posedge clk);
    #1;
    chk("abort_done_after_edge", {31'b0, done}, 32'd0);
    reset = 1'b0;
    @(posedge clk);
    #1;
    run_op("after_reset_mul", 3'd0, 32'd3, 32'd4, 32'd12);

    // randomized ops against the reference model, issued back to back
    for (int n = 0; n < 150; n++) begin
      f = 3'($urandom_range(0, 7));
      a = pick_operand();
      b = pick_operand();
      exp_q.push_back(ref_model(f, a, b));
      issue(f, a, b);
      wait_done(res, lat, bcnt);
      chk($sformatf("rand%0d_f%0d_%h_%h", n, f, a, b), res, exp_q.pop_front());
      chk($sformatf("rand%0d_latency", n), 32'(lat), 32'(exp_lat(f, a, b)));
    end

    // final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
